// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receiver and its baud tick generator.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN.
package uart_rx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_e;

    // Accumulator increment giving a carry at baud*ovs Hz; same formula the TX uses with ovs=1.
    function automatic longint unsigned baud_gen_inc(input longint unsigned clk_freq,
                                                     input longint unsigned baud,
                                                     input longint unsigned ovs,
                                                     input longint unsigned acc_w);
        return (((baud * ovs) << (acc_w - 64'd4)) + (clk_freq >> 5)) / (clk_freq >> 4);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side holding register handshake between uart_rx (master) and its consumer (slave).
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              overrun;
`ifdef UART_RX_PARITY_EN
    logic              parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output rx_data, rx_valid, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  rx_data, rx_valid, frame_err, overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Fractional accumulator producing a one-clock tick at BAUD*OVERSAMPLE Hz.
// Shared with the transmitter (OVERSAMPLE=1); the receiver uses 16.
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_WIDTH  = 16
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam longint unsigned INC_L = baud_gen_inc(64'(CLK_FREQ), 64'(BAUD),
                                                     64'(OVERSAMPLE), 64'(ACC_WIDTH));
    localparam logic [ACC_WIDTH:0] BAUD_GEN_INC = (ACC_WIDTH+1)'(INC_L);

    logic [ACC_WIDTH:0] acc_q, acc_d;

    // Carry out of the previous add is dropped here and exposed as the tick.
    always_comb begin
        acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + BAUD_GEN_INC;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end

    assign tick = acc_q[ACC_WIDTH];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, LSB-first, valid/ready holding register,
// framing-error and overrun pulses. Define UART_RX_PARITY_EN for an even parity bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ           = 50000000,
    parameter int unsigned BAUD               = 9600,
    parameter int unsigned BAUD_GEN_ACC_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    uart_rx_if.master  bus
);

    logic              tick;
    logic              rx_s;
    logic              deliver_c;
    logic [1:0]        sync_q, sync_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              par_bad_q, par_bad_d;
`ifdef UART_RX_PARITY_EN
    logic              perr_q, perr_d;
`endif

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16),
        .ACC_WIDTH  (BAUD_GEN_ACC_WIDTH)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], rx};
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        par_bad_d = par_bad_q;
        deliver_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                par_bad_d = 1'b0;
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            // Mid start bit re-check rejects glitches shorter than half a bit.
            START: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(7)) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            cnt_d   = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(15)) begin
                        shift_d = {rx_s, shift_q[DATA_W-1:1]};
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(DATA_W-1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(15)) begin
                        par_bad_d = ^{shift_q, rx_s};
                        perr_d    = ^{shift_q, rx_s};
                        state_d   = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(15)) begin
                        if (rx_s) begin
                            deliver_c = !par_bad_q;
                            state_d   = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end
                end
            end
            // Hold off a break so a held-low line cannot retrigger START.
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (deliver_c) begin
            if (!valid_q || bus.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            par_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            par_bad_q <= par_bad_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames in, expected bytes/error counts queued,
// a forked monitor pops and compares on each holding-register handshake.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 614400;
    localparam int unsigned BAUD     = 9600;
    localparam int          BIT_CLKS = 64;

    logic clk = 1'b0;
    logic reset_n;
    logic rx;

    uart_rx_if bus();

    uart_rx #(
        .CLK_FREQ           (CLK_FREQ),
        .BAUD               (BAUD),
        .BAUD_GEN_ACC_WIDTH (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int frame_cnt = 0;
    int ovr_cnt = 0;
    int par_cnt = 0;
    int hs_cnt = 0;
    int exp_frame = 0;
    int exp_ovr = 0;
    int exp_par = 0;
    int exp_hs = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic mon_loop();
        forever begin
            @(negedge clk);
            if (bus.frame_err === 1'b1) frame_cnt++;
            if (bus.overrun === 1'b1) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (bus.parity_err === 1'b1) par_cnt++;
`endif
            if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_byte got=%02h exp=none", bus.rx_data);
                end else begin
                    check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_bits,
                              input logic par_flip);
        line(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) line(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        line((^d) ^ par_flip, BIT_CLKS);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        line(stop_v, stop_bits * BIT_CLKS);
    endtask

    task automatic send_ok(input logic [7:0] d);
        exp_q.push_back(d);
        exp_hs++;
        send_frame(d, 1'b1, 1, 1'b0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 bus.rx_ready = v;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_handshakes"}, 32'(hs_cnt), 32'(exp_hs));
        check({tag, "_frame_err"}, 32'(frame_cnt), 32'(exp_frame));
        check({tag, "_overrun"}, 32'(ovr_cnt), 32'(exp_ovr));
    endtask

    initial begin
        reset_n = 1'b0;
        rx = 1'b1;
        bus.rx_ready = 1'b1;
        fork
            mon_loop();
        join_none
        repeat (5) @(negedge clk);
        check("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        check("reset_overrun", 32'(bus.overrun), 32'd0);
        reset_n = 1'b1;
        line(1'b1, 2 * BIT_CLKS);

        // Clean byte
        send_ok(8'h61);
        line(1'b1, BIT_CLKS);
        check_state("clean");

        // Back-to-back, no idle between stop and next start
        send_ok(8'h00);
        send_ok(8'hFF);
        line(1'b1, 2 * BIT_CLKS);
        check_state("b2b");

        // Glitch shorter than half a bit
        line(1'b0, 20);
        line(1'b1, 2 * BIT_CLKS);
        check_state("glitch");
        send_ok(8'h55);
        line(1'b1, BIT_CLKS);
        check_state("post_glitch");

        // Framing error: stop held low for two bit times
        send_frame(8'hA5, 1'b0, 2, 1'b0);
        exp_frame++;
        line(1'b1, 2 * BIT_CLKS);
        check_state("framing");
        send_ok(8'h3C);
        line(1'b1, BIT_CLKS);
        check_state("post_framing");

        // Overrun: second byte arrives while the first is still held
        set_ready(1'b0);
        exp_q.push_back(8'h11);
        exp_hs++;
        send_frame(8'h11, 1'b1, 1, 1'b0);
        line(1'b1, BIT_CLKS);
        send_frame(8'h22, 1'b1, 1, 1'b0);
        exp_ovr++;
        line(1'b1, BIT_CLKS);
        check("ovr_valid_held", 32'(bus.rx_valid), 32'd1);
        check("ovr_data_held", 32'(bus.rx_data), 32'h11);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        check("ovr_valid_drop", 32'(bus.rx_valid), 32'd0);
        check_state("overrun");

        // Reset during bit 4 of 0x7E, with a byte sitting in the holding register
        set_ready(1'b0);
        send_frame(8'h44, 1'b1, 1, 1'b0);
        line(1'b1, BIT_CLKS);
        check("pre_reset_valid", 32'(bus.rx_valid), 32'd1);
        line(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) line(1'(8'h7E >> i), BIT_CLKS);
        line(1'b1, BIT_CLKS / 2);
        reset_n = 1'b0;
        #1;
        check("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        check("midrst_overrun", 32'(bus.overrun), 32'd0);
        bus.rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        line(1'b1, 2 * BIT_CLKS);
        send_ok(8'h81);
        line(1'b1, BIT_CLKS);
        check_state("post_reset");

`ifdef UART_RX_PARITY_EN
        // Wrong parity: pulse, no delivery
        send_frame(8'h07, 1'b1, 1, 1'b1);
        exp_par++;
        line(1'b1, BIT_CLKS);
        check("parity_err_cnt", 32'(par_cnt), 32'(exp_par));
        check_state("parity");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
